fcvt_ctrl: RTL
==============

# fcvt_ctrl

Request controller for the shared integer-to-single-precision conversion datapath (`fcvt.s.w`). It arbitrates between `NREQ` requesters using valid/ready handshakes and registers the selected operand into the combinational converter. It then captures the converter's result into an output register and holds that result under result-side backpressure. It sits between the FP issue slots and the conversion datapath, so only one conversion is in flight at any time.

## Interface
- `NREQ`, 2, number of requesters (2..8).
- `TAGW`, 5, width of the destination tag carried with each request.
- `clk` in 1: rising-edge clock.
- `resetn` in 1: reset, asynchronous, active-high (asserted = 1).
- `req_valid` in NREQ: per-requester request valid.
- `req_ready` out NREQ: per-requester accept; one-hot or zero.
- `req_op` in 32*NREQ: operand of requester i in bits [32i+31:32i].
- `req_tag` in TAGW*NREQ: tag of requester i in bits [TAGW*i+TAGW-1:TAGW*i].
- `flush` in 1: kill the in-flight operation and block new accepts this cycle.
- `cvt_in` out 32: registered operand driven to the converter's `rs1`.
- `cvt_out` in 32: converter result, combinational from `cvt_in`.
- `res_valid` out 1: result valid.
- `res_ready` in 1: result consumer ready.
- `res_data` out 32: IEEE-754 single-precision result.
- `res_tag` out TAGW: tag of the result.
- `res_src` out $clog2(NREQ): index of the requester that issued the result.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, CONV, DONE.
- **Grant:**
  - `grant` selects one valid requester (arbitration is defined under Configuration).
  - `req_ready[grant]` = `req_valid[grant]` & ~`flush` & (state==IDLE | (state==DONE & `res_ready`)).
  - All other `req_ready` bits are 0.
- **IDLE:**
  - On accept, latch `req_op`/`req_tag`/`grant` into `op_q`/`tag_q`/`src_q` and go to CONV.
  - Otherwise stay in IDLE.
- **CONV:**
  - `cvt_in` = `op_q`.
  - At the next edge, `res_data` <= `cvt_out`, `res_tag` <= `tag_q`, `res_src` <= `src_q`, `res_valid` <= 1, then go to DONE.
  - If `flush`=1, go to IDLE, do not write the result registers, and keep `res_valid`=0.
- **DONE:**
  - `res_valid`=1 and all `res_*` outputs are held stable until `res_valid`&`res_ready`.
  - On the result handshake with a simultaneous accept, latch the new operand and go to CONV (back-to-back).
  - On the result handshake without an accept, go to IDLE and clear `res_valid`.
  - `flush` in DONE clears `res_valid` and goes to IDLE without a handshake. The result is dropped and no accept happens that cycle.
- `cvt_in` holds its last value outside CONV; the converter output is ignored there.
- The controller performs no arithmetic. `res_data` is bit-exact `cvt_out`. Zero and the sign bit are the datapath's responsibility.
- **Reset** (asynchronous, any state):
  - State = IDLE.
  - `res_valid`=0, `res_data`=0, `res_tag`=0, `res_src`=0.
  - `op_q`/`cvt_in`=0, `busy`=0.
  - Round-robin pointer = NREQ-1, so requester 0 wins first.
  - An operation in flight at reset is lost and no result is produced.

## Timing
- Accept at edge E, then CONV in cycle E..E+1. `res_valid` rises after edge E+1.
- Latency from request-cycle to result-visible is 2 cycles. Throughput is one conversion per 2 cycles with `res_ready` held at 1.
- `req_ready` depends combinationally on `req_valid`, `res_ready`, `flush` and state. `res_*` are registered outputs only.
- Requesters must hold `req_valid`/`req_op`/`req_tag` until accepted. `req_ready` is never asserted to a requester whose `req_valid`=0.
- `res_ready` held low in DONE stalls indefinitely with no loss.
- `busy` is registered from the state.

## Configuration
- `FCVT_CTRL_RR_EN`
  - Defined: round-robin arbitration. The pointer holds the last granted index and updates only on an accept. The search starts at pointer+1 and wraps modulo NREQ.
  - Undefined: fixed priority, where the lowest valid index wins and no pointer register exists.

## Test plan
- **Single conversion:** requester 0 sends `req_op`=0x00000005, tag 3, with `res_ready`=1. Required: `req_ready[0]` in the request cycle; `res_valid` 2 cycles later with `res_data`=0x40A00000, `res_tag`=3, `res_src`=0.
- **Negative and zero operands:** ops 0xFFFFFFFF then 0x00000000. Required: results 0xBF800000 then 0x00000000; second accept in the same cycle as the first result handshake; back-to-back spacing is 2 cycles.
- **Contention:** both requesters hold valid with op0=1 and op1=2.
  - With `FCVT_CTRL_RR_EN`: grant order 0,1,0,1 and results 0x3F800000, 0x40000000 alternating.
  - Without it: requester 0 gets every grant while its valid is held.
- **Backpressure:** `res_ready`=0 for 5 cycles in DONE. Required: `res_*` stable, `req_ready` all 0, `busy`=1; handshake in cycle 6, then IDLE.
- **Flush:**
  - `flush` in CONV: no `res_valid`, IDLE next cycle.
  - `flush` in DONE: `res_valid` drops with no handshake; a request valid that same cycle is not accepted.
- **Async reset mid-operation:** assert `resetn` between clock edges while in CONV. Required: all outputs go to reset values immediately; after release, requester 0 is granted first.

Source files
------------

// File: rtl/fcvt_ctrl_if.sv
// fcvt_ctrl_if: requester, converter and result signals of fcvt_ctrl
interface fcvt_ctrl_if #(
   parameter int NREQ = 2,
   parameter int TAGW = 5
);
   localparam int SW = $clog2(NREQ);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [32*NREQ-1:0]   req_op;
   logic [TAGW*NREQ-1:0] req_tag;
   logic                 flush;
   logic [31:0]          cvt_in;
   logic [31:0]          cvt_out;
   logic                 res_valid;
   logic                 res_ready;
   logic [31:0]          res_data;
   logic [TAGW-1:0]      res_tag;
   logic [SW-1:0]        res_src;
   logic                 busy;
   modport slave (
      input  req_valid, req_op, req_tag, flush, cvt_out, res_ready,
      output req_ready, cvt_in, res_valid, res_data, res_tag, res_src, busy
   );
   modport master (
      output req_valid, req_op, req_tag, flush, cvt_out, res_ready,
      input  req_ready, cvt_in, res_valid, res_data, res_tag, res_src, busy
   );
endinterface

// File: rtl/fcvt_ctrl.sv
// fcvt_ctrl: arbitrated request controller for the shared fcvt.s.w datapath
// Define FCVT_CTRL_RR_EN for round-robin arbitration; fixed priority otherwise.
module fcvt_ctrl #(
   parameter int NREQ = 2,
   parameter int TAGW = 5
) (
   input logic        clk,
   input logic        resetn,
   fcvt_ctrl_if.slave bus
);
   localparam int SW = $clog2(NREQ);
   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
   state_t          state, state_d;
   logic [SW-1:0]   grant, src_q;
   logic [31:0]     op_q;
   logic [TAGW-1:0] tag_q;
   logic            accept;
   logic [31:0]     ops  [NREQ];
   logic [TAGW-1:0] tags [NREQ];
   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign ops[g]  = bus.req_op[32*g +: 32];
      assign tags[g] = bus.req_tag[TAGW*g +: TAGW];
   end
`ifdef FCVT_CTRL_RR_EN
   logic [SW-1:0] ptr_q;
   // Descending scan so the index closest after the pointer wins.
   always_comb begin
      int idx;
      idx = 0;
      grant = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (bus.req_valid[SW'(idx)]) grant = SW'(idx);
      end
   end
   always_ff @(posedge clk or posedge resetn)
      if (resetn) ptr_q <= SW'(NREQ - 1);
      else if (accept) ptr_q <= grant;
`else
   always_comb begin
      grant = '0;
      for (int k = NREQ - 1; k >= 0; k--)
         if (bus.req_valid[SW'(k)]) grant = SW'(k);
   end
`endif
   assign accept = (|bus.req_valid) & ~bus.flush & (state == IDLE | (state == DONE & bus.res_ready));
   assign bus.req_ready = accept ? NREQ'(1) << grant : '0;
   assign bus.cvt_in = op_q;
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    state_d = accept ? CONV : IDLE;
         CONV:    state_d = bus.flush ? IDLE : DONE;
         DONE:    state_d = accept ? CONV : (bus.flush | bus.res_ready) ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge resetn)
      if (resetn) begin
         state         <= IDLE;
         bus.busy      <= 1'b0;
         bus.res_valid <= 1'b0;
         bus.res_data  <= '0;
         bus.res_tag   <= '0;
         bus.res_src   <= '0;
         op_q          <= '0;
         tag_q         <= '0;
         src_q         <= '0;
      end else begin
         state         <= state_d;
         bus.busy      <= state_d != IDLE;
         bus.res_valid <= state_d == DONE;
         if (accept) begin
            op_q  <= ops[grant];
            tag_q <= tags[grant];
            src_q <= grant;
         end
         if (state == CONV && !bus.flush) begin
            bus.res_data <= bus.cvt_out;
            bus.res_tag  <= tag_q;
            bus.res_src  <= src_q;
         end
      end
endmodule
